// File: rtl/uart_tx_buffer_if.sv
// Byte-stream interface between the APB/transmitter side and uart_tx_buffer.
// UART_TX_BUF_THRESH_EN adds the thresh/thresh_irq pair.
interface uart_tx_buffer_if #(
    parameter int DEPTH = 16
) ();
    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          flush;
    logic          clr_overflow;
    logic [7:0]    tx_data;
    logic          start_tx;
    logic          start_tx_re_cfg;
    logic          tx_done;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          tx_busy;
`ifdef UART_TX_BUF_THRESH_EN
    logic [AW:0]   thresh;
    logic          thresh_irq;
`endif

    modport master (
        output wr_en, wr_data, flush, clr_overflow, start_tx_re_cfg, tx_done,
`ifdef UART_TX_BUF_THRESH_EN
        output thresh,
        input  thresh_irq,
`endif
        input  tx_data, start_tx, full, empty, count, overflow, tx_busy
    );

    modport slave (
        input  wr_en, wr_data, flush, clr_overflow, start_tx_re_cfg, tx_done,
`ifdef UART_TX_BUF_THRESH_EN
        input  thresh,
        output thresh_irq,
`endif
        output tx_data, start_tx, full, empty, count, overflow, tx_busy
    );
endinterface

// File: rtl/uart_tx_buffer.sv
// TX byte FIFO feeding the UART transmitter; holds each byte stable for a whole frame.
// Optional UART_TX_BUF_THRESH_EN adds a registered "FIFO low" interrupt (count <= thresh).
module uart_tx_buffer #(
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_tx_buffer_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_CLR, WAIT_DONE} state_t;

    state_t         state_q;
    logic [7:0]     mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           overflow_q, overflow_d;
    logic [7:0]     tx_data_q;
    logic           start_tx_q;
    logic           tx_busy_q;
    logic           full_w, empty_w;
    logic           push, pop, drop;

    assign full_w  = (count_q == (AW+1)'(DEPTH));
    assign empty_w = (count_q == '0);

    // Flush suppresses both push and pop so the cleared FIFO stays empty.
    assign push = bus.wr_en && !full_w && !bus.flush;
    assign drop = bus.wr_en &&  full_w && !bus.flush;
    assign pop  = (state_q == IDLE) && !empty_w && !bus.flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + (AW+1)'(1);
            else if (pop && !push) count_d = count_q - (AW+1)'(1);
        end
        if (drop)                  overflow_d = 1'b1;
        else if (bus.clr_overflow) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            start_tx_q <= 1'b0;
            tx_busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        tx_data_q  <= mem_q[rd_ptr_q];
                        start_tx_q <= 1'b1;
                        tx_busy_q  <= 1'b1;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (bus.start_tx_re_cfg) begin
                        start_tx_q <= 1'b0;
                        state_q    <= WAIT_CLR;
                    end
                end
                // Wait out the previous frame's done level before watching for a new one.
                WAIT_CLR: begin
                    if (!bus.tx_done) state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.tx_done) begin
                        tx_busy_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    start_tx_q <= 1'b0;
                    tx_busy_q  <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_BUF_THRESH_EN
    logic thresh_irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) thresh_irq_q <= 1'b0;
        else          thresh_irq_q <= (count_q <= bus.thresh);
    end

    assign bus.thresh_irq = thresh_irq_q;
`endif

    assign bus.tx_data  = tx_data_q;
    assign bus.start_tx = start_tx_q;
    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.tx_busy  = tx_busy_q;
endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a behavioural transmitter acting on the falling edge.
module tb_uart_tx_buffer;
    localparam int DEPTH     = 16;
    localparam int FRAME_LEN = 6;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    uart_tx_buffer_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_buffer #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int         total = 0;
    int         passed = 0;
    int         ack_delay = 3;
    bit         stall = 1'b0;
    int         stab_err = 0;
    logic [7:0] rx_q [$];

    // Transmitter model: acks ack_delay cycles after seeing start_tx, clears done at ack,
    // raises done FRAME_LEN cycles later, and checks tx_data stays put for the frame.
    initial begin : tx_model
        int         m_state;
        int         cnt;
        logic [7:0] fb;
        m_state = 0;
        cnt = 0;
        fb = '0;
        bus.tx_done = 1'b0;
        bus.start_tx_re_cfg = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_state = 0;
                cnt = 0;
                bus.tx_done = 1'b0;
                bus.start_tx_re_cfg = 1'b0;
            end else begin
                case (m_state)
                    0: if (bus.start_tx && !stall) begin
                        fb = bus.tx_data;
                        cnt = 1;
                        m_state = 1;
                    end
                    1: begin
                        if (bus.tx_data !== fb) stab_err++;
                        if (cnt >= ack_delay) begin
                            bus.start_tx_re_cfg = 1'b1;
                            bus.tx_done = 1'b0;
                            rx_q.push_back(fb);
                            cnt = 0;
                            m_state = 2;
                        end else cnt++;
                    end
                    default: begin
                        if (bus.tx_data !== fb) stab_err++;
                        cnt++;
                        if (cnt == 2) bus.start_tx_re_cfg = 1'b0;
                        if (cnt == FRAME_LEN) begin
                            bus.tx_done = 1'b1;
                            m_state = 0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(bus.tx_busy == 1'b0 && bus.empty == 1'b1 && bus.start_tx == 1'b0) && n < 1000) begin
            tick();
            n++;
        end
        total++;
        if (n >= 1000) $display("FAIL %s_idle: timed out, tx_busy=%0b empty=%0b required 0/1", name, bus.tx_busy, bus.empty);
        else passed++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        bus.flush = 1'b0;
        bus.clr_overflow = 1'b0;
        #12;
        total++; if (bus.tx_data !== 8'h00) $display("FAIL rst_tx_data: got %0h required 0", bus.tx_data); else passed++;
        total++; if (bus.start_tx !== 1'b0) $display("FAIL rst_start_tx: got %0b required 0", bus.start_tx); else passed++;
        total++; if (bus.full !== 1'b0) $display("FAIL rst_full: got %0b required 0", bus.full); else passed++;
        total++; if (bus.empty !== 1'b1) $display("FAIL rst_empty: got %0b required 1", bus.empty); else passed++;
        total++; if (bus.count !== 5'd0) $display("FAIL rst_count: got %0d required 0", bus.count); else passed++;
        total++; if (bus.overflow !== 1'b0) $display("FAIL rst_overflow: got %0b required 0", bus.overflow); else passed++;
        total++; if (bus.tx_busy !== 1'b0) $display("FAIL rst_tx_busy: got %0b required 0", bus.tx_busy); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_byte();
        int n;
        bit held_ok;
        rx_q.delete();
        stab_err = 0;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hA5;
        tick();
        bus.wr_en = 1'b0;
        total++; if (bus.count !== 5'd1) $display("FAIL single_count_after_push: got %0d required 1", bus.count); else passed++;
        total++; if (bus.start_tx !== 1'b0) $display("FAIL single_start_early: got %0b required 0", bus.start_tx); else passed++;
        tick();
        total++; if (bus.tx_data !== 8'hA5) $display("FAIL single_tx_data: got %0h required a5", bus.tx_data); else passed++;
        total++; if (bus.start_tx !== 1'b1) $display("FAIL single_start_tx: got %0b required 1", bus.start_tx); else passed++;
        total++; if (bus.count !== 5'd0) $display("FAIL single_count_after_pop: got %0d required 0", bus.count); else passed++;
        total++; if (bus.tx_busy !== 1'b1) $display("FAIL single_busy: got %0b required 1", bus.tx_busy); else passed++;
        n = 0;
        held_ok = 1'b1;
        while (n < 30) begin
            tick();
            n++;
            if (bus.start_tx_re_cfg) break;
            if (bus.start_tx !== 1'b1) held_ok = 1'b0;
        end
        total++; if (n >= 30) $display("FAIL single_ack_wait: timed out, ack=%0b required 1", bus.start_tx_re_cfg); else passed++;
        total++; if (!held_ok) $display("FAIL single_start_held: got start_tx dropped before ack required held"); else passed++;
        total++; if (bus.start_tx !== 1'b0) $display("FAIL single_start_drop: got %0b required 0", bus.start_tx); else passed++;
        n = 0;
        while (n < 30) begin
            tick();
            n++;
            if (bus.tx_done) break;
        end
        total++; if (n >= 30) $display("FAIL single_done_wait: timed out, tx_done=%0b required 1", bus.tx_done); else passed++;
        total++; if (bus.tx_busy !== 1'b0) $display("FAIL single_busy_end: got %0b required 0", bus.tx_busy); else passed++;
        total++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) $display("FAIL single_rx: got size %0d required one byte a5", rx_q.size()); else passed++;
        total++; if (stab_err != 0) $display("FAIL single_stable: got %0d changes required 0", stab_err); else passed++;
        wait_idle("single");
    endtask

    task automatic test_back_to_back();
        int n;
        int run;
        int gaps[$];
        rx_q.delete();
        stab_err = 0;
        bus.wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_data = 8'(i + 1);
            tick();
        end
        bus.wr_en = 1'b0;
        n = 0;
        run = 0;
        while (n < 400 && !(rx_q.size() == 3 && !bus.tx_busy)) begin
            tick();
            n++;
            if (!bus.tx_busy) run++;
            else if (run > 0) begin
                gaps.push_back(run);
                run = 0;
            end
        end
        total++; if (n >= 400) $display("FAIL burst_wait: timed out, received %0d required 3", rx_q.size()); else passed++;
        total++; if (rx_q.size() != 3) $display("FAIL burst_rx_count: got %0d required 3", rx_q.size()); else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= rx_q.size() || rx_q[i] !== 8'(i + 1)) $display("FAIL burst_order_%0d: got %0h required %0h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, 8'(i + 1));
            else passed++;
        end
        total++; if (gaps.size() != 2) $display("FAIL burst_gap_count: got %0d required 2", gaps.size()); else passed++;
        for (int i = 0; i < gaps.size(); i++) begin
            total++; if (gaps[i] != 1) $display("FAIL burst_gap_%0d: got %0d idle cycles required 1", i, gaps[i]); else passed++;
        end
        total++; if (stab_err != 0) $display("FAIL burst_stable: got %0d changes required 0", stab_err); else passed++;
        wait_idle("burst");
    endtask

    task automatic test_overflow();
        int n;
        rx_q.delete();
        stab_err = 0;
        stall = 1'b1;
        bus.wr_en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            bus.wr_data = 8'(8'h10 + i);
            tick();
        end
        bus.wr_en = 1'b0;
        total++; if (bus.count !== 5'd16) $display("FAIL ovf_count: got %0d required 16", bus.count); else passed++;
        total++; if (bus.full !== 1'b1) $display("FAIL ovf_full: got %0b required 1", bus.full); else passed++;
        total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_flag: got %0b required 1", bus.overflow); else passed++;
        total++; if (bus.tx_data !== 8'h10) $display("FAIL ovf_head: got %0h required 10", bus.tx_data); else passed++;
        repeat (3) tick();
        total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky: got %0b required 1", bus.overflow); else passed++;
        bus.clr_overflow = 1'b1;
        tick();
        bus.clr_overflow = 1'b0;
        total++; if (bus.overflow !== 1'b0) $display("FAIL ovf_clear: got %0b required 0", bus.overflow); else passed++;
        stall = 1'b0;
        n = 0;
        while (n < 1000 && !(rx_q.size() == 17 && !bus.tx_busy)) begin
            tick();
            n++;
        end
        total++; if (rx_q.size() != 17) $display("FAIL ovf_drain_count: got %0d required 17", rx_q.size()); else passed++;
        for (int i = 0; i < 17; i++) begin
            total++;
            if (i >= rx_q.size() || rx_q[i] !== 8'(8'h10 + i)) $display("FAIL ovf_drain_%0d: got %0h required %0h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, 8'(8'h10 + i));
            else passed++;
        end
        total++; if (stab_err != 0) $display("FAIL ovf_stable: got %0d changes required 0", stab_err); else passed++;
        wait_idle("ovf");
    endtask

    task automatic test_full_with_pop();
        int n;
        rx_q.delete();
        stall = 1'b1;
        bus.wr_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.wr_data = 8'(8'h50 + i);
            tick();
        end
        bus.wr_en = 1'b0;
        total++; if (bus.full !== 1'b1) $display("FAIL fullpop_pre_full: got %0b required 1", bus.full); else passed++;
        total++; if (bus.overflow !== 1'b0) $display("FAIL fullpop_pre_ovf: got %0b required 0", bus.overflow); else passed++;
        stall = 1'b0;
        n = 0;
        while (n < 200 && bus.tx_busy) begin
            tick();
            n++;
        end
        total++; if (n >= 200) $display("FAIL fullpop_wait: timed out, tx_busy=%0b required 0", bus.tx_busy); else passed++;
        // FSM is in IDLE with a full FIFO: the next edge pops while this write arrives.
        stall = 1'b1;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h77;
        tick();
        bus.wr_en = 1'b0;
        total++; if (bus.count !== 5'd15) $display("FAIL fullpop_count: got %0d required 15", bus.count); else passed++;
        total++; if (bus.overflow !== 1'b1) $display("FAIL fullpop_ovf: got %0b required 1", bus.overflow); else passed++;
        total++; if (bus.full !== 1'b0) $display("FAIL fullpop_full: got %0b required 0", bus.full); else passed++;
        total++; if (bus.tx_data !== 8'h51) $display("FAIL fullpop_tx_data: got %0h required 51", bus.tx_data); else passed++;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h78;
        tick();
        bus.wr_data = 8'h79;
        bus.clr_overflow = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set_priority: got %0b required 1", bus.overflow); else passed++;
        total++; if (bus.count !== 5'd16) $display("FAIL ovf_priority_count: got %0d required 16", bus.count); else passed++;
        tick();
        bus.clr_overflow = 1'b0;
        total++; if (bus.overflow !== 1'b0) $display("FAIL ovf_clr_alone: got %0b required 0", bus.overflow); else passed++;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        total++; if (bus.count !== 5'd0) $display("FAIL fullpop_flush: got %0d required 0", bus.count); else passed++;
        stall = 1'b0;
        wait_idle("fullpop");
    endtask

    task automatic test_flush_mid_frame();
        int n;
        rx_q.delete();
        stab_err = 0;
        ack_delay = 8;
        bus.wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.wr_data = 8'(8'h30 + i);
            tick();
        end
        bus.wr_en = 1'b0;
        total++; if (bus.count !== 5'd5) $display("FAIL flush_pre_count: got %0d required 5", bus.count); else passed++;
        n = 0;
        while (n < 50 && bus.start_tx) begin
            tick();
            n++;
        end
        total++; if (n >= 50) $display("FAIL flush_ack_wait: timed out, start_tx=%0b required 0", bus.start_tx); else passed++;
        tick();
        bus.flush = 1'b1;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hEE;
        tick();
        bus.flush = 1'b0;
        bus.wr_en = 1'b0;
        total++; if (bus.count !== 5'd0) $display("FAIL flush_count: got %0d required 0", bus.count); else passed++;
        total++; if (bus.empty !== 1'b1) $display("FAIL flush_empty: got %0b required 1", bus.empty); else passed++;
        total++; if (bus.overflow !== 1'b0) $display("FAIL flush_ovf: got %0b required 0", bus.overflow); else passed++;
        total++; if (bus.tx_data !== 8'h30) $display("FAIL flush_tx_data: got %0h required 30", bus.tx_data); else passed++;
        total++; if (bus.tx_busy !== 1'b1) $display("FAIL flush_busy: got %0b required 1", bus.tx_busy); else passed++;
        n = 0;
        while (n < 50 && bus.tx_busy) begin
            tick();
            n++;
        end
        total++; if (rx_q.size() != 1 || rx_q[0] !== 8'h30) $display("FAIL flush_rx: got size %0d required one byte 30", rx_q.size()); else passed++;
        total++; if (stab_err != 0) $display("FAIL flush_stable: got %0d changes required 0", stab_err); else passed++;
        repeat (4) tick();
        total++; if (bus.tx_busy !== 1'b0) $display("FAIL flush_stay_idle: got %0b required 0", bus.tx_busy); else passed++;
        total++; if (bus.start_tx !== 1'b0) $display("FAIL flush_no_start: got %0b required 0", bus.start_tx); else passed++;
        ack_delay = 3;
    endtask

    task automatic test_reset_mid_send();
        stall = 1'b1;
        bus.wr_en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            bus.wr_data = 8'(8'h40 + i);
            tick();
        end
        bus.wr_en = 1'b0;
        total++; if (bus.start_tx !== 1'b1) $display("FAIL rstmid_pre_start: got %0b required 1", bus.start_tx); else passed++;
        total++; if (bus.overflow !== 1'b1) $display("FAIL rstmid_pre_ovf: got %0b required 1", bus.overflow); else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (bus.start_tx !== 1'b0) $display("FAIL rstmid_start: got %0b required 0", bus.start_tx); else passed++;
        total++; if (bus.count !== 5'd0) $display("FAIL rstmid_count: got %0d required 0", bus.count); else passed++;
        total++; if (bus.tx_data !== 8'h00) $display("FAIL rstmid_tx_data: got %0h required 0", bus.tx_data); else passed++;
        total++; if (bus.overflow !== 1'b0) $display("FAIL rstmid_ovf: got %0b required 0", bus.overflow); else passed++;
        total++; if (bus.empty !== 1'b1) $display("FAIL rstmid_empty: got %0b required 1", bus.empty); else passed++;
        total++; if (bus.tx_busy !== 1'b0) $display("FAIL rstmid_busy: got %0b required 0", bus.tx_busy); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        stall = 1'b0;
        tick();
        tick();
        total++; if (bus.start_tx !== 1'b0) $display("FAIL rstmid_after_start: got %0b required 0", bus.start_tx); else passed++;
        total++; if (bus.tx_busy !== 1'b0) $display("FAIL rstmid_after_busy: got %0b required 0", bus.tx_busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_full_with_pop();
        test_flush_mid_frame();
        test_reset_mid_send();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Upstream feeder for the UART transmitter. Buffers bytes written by the APB register block in a synchronous FIFO.
- Presents one byte at a time on tx_data, raises start_tx, and holds the byte stable until the transmitter reports frame completion.
- Sits between the APB TX data register write strobe and the transmitter's tx_data/start_tx/tx_done/start_tx_re_cfg interface.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- wr_en  in  1  push strobe from APB write to the TX data register
- wr_data  in  8  byte to push
- flush  in  1  single-cycle FIFO clear
- clr_overflow  in  1  clears the overflow flag
- tx_data  out  8  byte currently offered to or being sent by the transmitter
- start_tx  out  1  request to the transmitter (level)
- start_tx_re_cfg  in  1  transmitter acknowledge; high once the start bit has begun
- tx_done  in  1  transmitter done level; goes high at end of frame and stays high until the next start_tx is accepted
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky; set when a write is dropped
- tx_busy  out  1  FSM not in IDLE

Behaviour:
- Reset (reset_n low, asynchronous) values:
  - tx_data=0, start_tx=0, full=0, empty=1, count=0, overflow=0, tx_busy=0.
  - FSM=IDLE; rd/wr pointers=0; FIFO contents are don't-care.
- FIFO:
  - Registered storage. Pointers are AW bits and wrap modulo DEPTH.
  - count is a registered AW+1-bit counter. full=(count==DEPTH), empty=(count==0), both registered/derived from registered count.
  - Push: wr_en && !full writes wr_data at wr_ptr, wr_ptr+1.
  - wr_en && full: byte dropped, overflow<=1. The full check uses the pre-edge value, so a write is dropped even if a pop occurs on the same edge.
  - Simultaneous push and pop (not full): count unchanged, both pointers advance.
  - overflow clears on clr_overflow. Set has priority over clear on the same edge.
  - flush: both pointers and count go to 0 on the next edge. A same-cycle wr_en is ignored and does not set overflow. The in-flight frame (tx_data, FSM) is unaffected.
- FSM, all outputs registered:
  - IDLE: if !empty and !flush, pop the head into tx_data, start_tx<=1, go to SEND.
  - SEND: hold start_tx=1 and tx_data. When start_tx_re_cfg==1, start_tx<=0 and go to WAIT_CLR.
  - WAIT_CLR: wait for tx_done==0 (the previous done level has been cleared by the transmitter), then go to WAIT_DONE. If tx_done is already 0, leave after one cycle.
  - WAIT_DONE: on tx_done==1, go to IDLE.
  - tx_data changes only on the IDLE pop edge. The transmitter computes parity from tx_data throughout the frame, so the byte must stay stable through WAIT_DONE.
  - tx_busy=(state!=IDLE).
- Latency:
  - Push into an empty FIFO with the FSM in IDLE at edge E0: count=1 after E0; pop, tx_data valid and start_tx=1 after E1.
  - Back-to-back frames: one IDLE cycle between WAIT_DONE exit and the next start_tx.
- Transmitter flow control (cts_n) is invisible here: start_tx simply stays high in SEND until acknowledged. There is no timeout.
- Reset mid-frame returns to IDLE immediately and start_tx drops. The transmitter is reset by the same reset_n.

Optional Feature:
- Macro UART_TX_BUF_THRESH_EN.
- Defined:
  - Adds input thresh[AW:0] and output thresh_irq.
  - thresh_irq is registered, equals (count<=thresh), resets to 0 and becomes valid from the first edge after reset.
  - Used as a "TX FIFO low" interrupt source.
- Undefined: neither port exists and no comparator is built.

Test Plan:
- Single byte: push 0xA5 into an empty FIFO; tx model acks 3 cycles after start_tx and drops/raises tx_done -> tx_data=0xA5 and start_tx=1 two edges after the push; start_tx=0 the edge after ack; tx_busy=0 after tx_done rises; count 1->0 on the pop edge.
- Burst order: push 0x01,0x02,0x03 on consecutive cycles -> transmitter receives 0x01,0x02,0x03 in order; one IDLE cycle between frames; tx_data is never changed mid-frame.
- Overflow: DEPTH=16, stall the ack, push 18 bytes -> first byte popped; 16 buffered, full=1; 18th write dropped; overflow=1 until clr_overflow; drained stream equals bytes 1..17.
- Full with simultaneous pop: full=1, push on the same cycle the FSM pops -> write dropped, overflow=1, count=15.
- Flush mid-frame: 5 bytes queued, frame in WAIT_DONE, assert flush with wr_en -> count=0, empty=1, overflow unchanged; current frame completes with its original tx_data; FSM stays IDLE afterwards.
- Reset mid-SEND: assert reset_n low while start_tx=1 -> start_tx, count, tx_data and overflow go to 0 asynchronously; empty=1.
